// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game controller: state encoding,
// keypad keycodes and winner encodings.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_e;

  localparam logic [4:0] KEY_UP    = 5'd2;
  localparam logic [4:0] KEY_DOWN  = 5'd8;
  localparam logic [4:0] KEY_START = 5'd5;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/key_cmd_decode.sv
// Per-player keypad decoder: paddle up/down levels and a start request that
// fires only on the rising edge of the key-held flag.
module key_cmd_decode
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_i,
  input  logic [4:0] keys_i,
  output logic       up_o,
  output logic       dn_o,
  output logic       start_o
);

  logic flag_q;

  always_ff @(posedge clk) begin
    if (rst) flag_q <= 1'b0;
    else     flag_q <= flag_i;
  end

  assign up_o    = flag_i && (keys_i == KEY_UP);
  assign dn_o    = flag_i && (keys_i == KEY_DOWN);
  assign start_o = flag_i && !flag_q && (keys_i == KEY_START);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: idle/serve/play/point/over phases, score keeping,
// ball enable/recentre and paddle commands. All outputs are registered.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [4:0]         keys_1,
  input  logic               flag_1,
  input  logic [4:0]         keys_2,
  input  logic               flag_2,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [1:0]         p1_move,
  output logic [1:0]         p2_move,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic [2:0]         state_o,
  output logic [1:0]         winner
);

  localparam int FRAMES_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = (FRAMES_MAX > 1) ? $clog2(FRAMES_MAX) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    if (v >= WIN_S) return WIN_S;
    return v + 1'b1;
  endfunction

  logic up1, dn1, st1, up2, dn2, st2;

  key_cmd_decode u_key1 (
    .clk(clk), .rst(rst), .flag_i(flag_1), .keys_i(keys_1),
    .up_o(up1), .dn_o(dn1), .start_o(st1)
  );

  key_cmd_decode u_key2 (
    .clk(clk), .rst(rst), .flag_i(flag_2), .keys_i(keys_2),
    .up_o(up2), .dn_o(dn2), .start_o(st2)
  );

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SCORE_W-1:0]   score1_q, score1_d, score2_q, score2_d;
  logic                 dir_q, dir_d;
  logic [1:0]           winner_q, winner_d;
  logic                 reset_d, reset_q, run_q;
  logic [1:0]           p1_q, p2_q;
  logic                 start_any, move_en;

  assign start_any = st1 || st2;
  assign move_en   = (state_q == SERVE) || (state_q == PLAY);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score1_d = score1_q;
    score2_d = score2_q;
    dir_d    = dir_q;
    winner_d = winner_q;
    reset_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_any) begin
          state_d = SERVE;
          reset_d = 1'b1;
          dir_d   = 1'b0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) state_d = PLAY;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end
      PLAY: begin
        // A simultaneous double miss is a dead ball: no score, serve unchanged.
        if (miss_l && miss_r) begin
          state_d = POINT;
        end else if (miss_l) begin
          score2_d = sat_inc(score2_q);
          dir_d    = 1'b0;
          state_d  = POINT;
        end else if (miss_r) begin
          score1_d = sat_inc(score1_q);
          dir_d    = 1'b1;
          state_d  = POINT;
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            if (score1_q == WIN_S) begin
              winner_d = WIN_P1;
              state_d  = OVER;
            end else if (score2_q == WIN_S) begin
              winner_d = WIN_P2;
              state_d  = OVER;
            end else begin
              state_d = SERVE;
              reset_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OVER: begin
        if (start_any) begin
          score1_d = '0;
          score2_d = '0;
          winner_d = WIN_NONE;
          reset_d  = 1'b1;
          state_d  = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      score1_q <= '0;
      score2_q <= '0;
      dir_q    <= 1'b0;
      winner_q <= WIN_NONE;
      reset_q  <= 1'b0;
      run_q    <= 1'b0;
      p1_q     <= 2'b00;
      p2_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      dir_q    <= dir_d;
      winner_q <= winner_d;
      reset_q  <= reset_d;
      // Ball enable tracks the state being entered so it lines up with state_o.
      run_q    <= (state_d == PLAY);
      p1_q     <= move_en ? {up1, dn1} : 2'b00;
      p2_q     <= move_en ? {up2, dn2} : 2'b00;
    end
  end

  assign ball_run   = run_q;
  assign ball_reset = reset_q;
  assign serve_dir  = dir_q;
  assign p1_move    = p1_q;
  assign p2_move    = p2_q;
  assign score_1    = score1_q;
  assign score_2    = score2_q;
  assign state_o    = state_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed game flow with randomized
// key/tick/miss noise, compared every cycle against a behavioural game model.
module tb_pong_game_ctrl;

  localparam int SCORE_W = 4;
  localparam int WIN     = 9;
  localparam int SF      = 60;
  localparam int PF      = 30;
  localparam int PH_IDLE = 0, PH_SERVE = 1, PH_PLAY = 2, PH_POINT = 3, PH_OVER = 4;

  logic clk = 1'b0;
  logic rst, frame_tick, flag_1, flag_2, miss_l, miss_r;
  logic [4:0] keys_1, keys_2;
  logic ball_run, ball_reset, serve_dir;
  logic [1:0] p1_move, p2_move, winner;
  logic [SCORE_W-1:0] score_1, score_2;
  logic [2:0] state_o;

  pong_game_ctrl #(
    .SCORE_W(SCORE_W), .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .keys_1(keys_1), .flag_1(flag_1), .keys_2(keys_2), .flag_2(flag_2),
    .miss_l(miss_l), .miss_r(miss_r),
    .ball_run(ball_run), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .p1_move(p1_move), .p2_move(p2_move),
    .score_1(score_1), .score_2(score_2),
    .state_o(state_o), .winner(winner)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Game model: phase, frames seen in the current phase, scores, outputs.
  int m_phase, m_frames, m_s1, m_s2, m_win, m_dir, m_run, m_reset, m_p1, m_p2;
  bit m_prev1, m_prev2;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int paddle(input bit f, input logic [4:0] k);
    if (!f) return 0;
    if (k == 5'd2) return 2;
    if (k == 5'd8) return 1;
    return 0;
  endfunction

  task automatic model_update();
    int old;
    bit start;
    if (rst) begin
      m_phase = PH_IDLE; m_frames = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_dir = 0; m_run = 0; m_reset = 0; m_p1 = 0; m_p2 = 0;
      m_prev1 = 0; m_prev2 = 0;
      return;
    end
    old = m_phase;
    start = (flag_1 && !m_prev1 && keys_1 == 5'd5) || (flag_2 && !m_prev2 && keys_2 == 5'd5);
    m_reset = 0;
    if (old == PH_SERVE || old == PH_PLAY) begin
      m_p1 = paddle(flag_1, keys_1);
      m_p2 = paddle(flag_2, keys_2);
    end else begin
      m_p1 = 0;
      m_p2 = 0;
    end
    if (old == PH_IDLE && start) begin
      m_phase = PH_SERVE; m_reset = 1; m_dir = 0;
    end else if (old == PH_SERVE && frame_tick) begin
      m_frames++;
      if (m_frames == SF) m_phase = PH_PLAY;
    end else if (old == PH_PLAY && (miss_l || miss_r)) begin
      m_phase = PH_POINT;
      if (miss_l && !miss_r) begin
        m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1;
        m_dir = 0;
      end else if (miss_r && !miss_l) begin
        m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
        m_dir = 1;
      end
    end else if (old == PH_POINT && frame_tick) begin
      m_frames++;
      if (m_frames == PF) begin
        if (m_s1 == WIN)      begin m_win = 1; m_phase = PH_OVER; end
        else if (m_s2 == WIN) begin m_win = 2; m_phase = PH_OVER; end
        else                  begin m_phase = PH_SERVE; m_reset = 1; end
      end
    end else if (old == PH_OVER && start) begin
      m_s1 = 0; m_s2 = 0; m_win = 0; m_reset = 1; m_phase = PH_SERVE;
    end
    if (m_phase != old) m_frames = 0;
    m_run = (m_phase == PH_PLAY);
    m_prev1 = flag_1;
    m_prev2 = flag_2;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("state", state_o, m_phase);
    chk("ball_run", ball_run, m_run);
    chk("ball_reset", ball_reset, m_reset);
    chk("serve_dir", serve_dir, m_dir);
    chk("p1_move", p1_move, m_p1);
    chk("p2_move", p2_move, m_p2);
    chk("score_1", score_1, m_s1);
    chk("score_2", score_2, m_s2);
    chk("winner", winner, m_win);
  endtask

  function automatic logic [4:0] pick_key();
    case ($urandom % 5)
      0: return 5'd2;
      1: return 5'd8;
      2: return 5'd5;
      3: return 5'd0;
      default: return 5'($urandom % 32);
    endcase
  endfunction

  task automatic quiet();
    flag_1 = 0; flag_2 = 0; keys_1 = 0; keys_2 = 0;
    frame_tick = 0; miss_l = 0; miss_r = 0;
  endtask

  task automatic noise(input bit allow_miss);
    flag_1 = 1'($urandom % 2);
    flag_2 = 1'($urandom % 2);
    keys_1 = pick_key();
    keys_2 = pick_key();
    frame_tick = ($urandom % 3) == 0;
    miss_l = allow_miss && ($urandom % 8) == 0;
    miss_r = allow_miss && ($urandom % 8) == 0;
  endtask

  task automatic run_until(input int target, input string tag);
    int n;
    n = 0;
    while (m_phase != target && n < 3000) begin
      noise(m_phase != PH_PLAY);
      step();
      n++;
    end
    chk(tag, state_o, target);
    quiet();
  endtask

  task automatic miss(input bit l, input bit r);
    quiet();
    miss_l = l;
    miss_r = r;
    step();
    quiet();
  endtask

  initial begin
    int n;
    quiet();
    rst = 1;
    step();
    step();
    rst = 0;
    chk("reset_state", state_o, PH_IDLE);
    chk("reset_run", ball_run, 0);

    // IDLE: paddle keys ignored, no start key used.
    for (int i = 0; i < 10; i++) begin
      noise(1);
      if (keys_1 == 5'd5) keys_1 = 5'd3;
      if (keys_2 == 5'd5) keys_2 = 5'd3;
      step();
    end
    quiet();
    flag_2 = 1; keys_2 = 5'd2;
    step();
    chk("p2_up_idle", p2_move, 0);

    // P1 start edge.
    quiet();
    step();
    flag_1 = 1; keys_1 = 5'd5;
    step();
    chk("start_reset", ball_reset, 1);
    chk("start_state", state_o, PH_SERVE);
    step();
    chk("start_reset_pulse", ball_reset, 0);

    run_until(PH_PLAY, "serve_to_play");
    chk("play_run", ball_run, 1);
    flag_2 = 1; keys_2 = 5'd2;
    step();
    chk("p2_up_play", p2_move, 2);

    miss(0, 1);
    chk("miss_r_s1", score_1, 1);
    chk("miss_r_dir", serve_dir, 1);
    chk("miss_r_state", state_o, PH_POINT);
    run_until(PH_SERVE, "point_to_serve");
    chk("point_serve_reset", ball_reset, 1);
    run_until(PH_PLAY, "serve_to_play2");

    miss(1, 1);
    chk("both_s1", score_1, 1);
    chk("both_s2", score_2, 0);
    chk("both_dir", serve_dir, 1);
    chk("both_state", state_o, PH_POINT);
    run_until(PH_SERVE, "both_to_serve");
    run_until(PH_PLAY, "both_to_play");

    for (int i = 0; i < 3; i++) begin
      n = $urandom % 3;
      miss(n != 1, n != 0);
      run_until(PH_SERVE, "rally_serve");
      run_until(PH_PLAY, "rally_play");
    end

    // P2 wins by repeated left misses.
    for (int i = 0; i < 12; i++) begin
      miss(1, 0);
      if (m_s2 >= WIN) break;
      run_until(PH_SERVE, "climb_serve");
      run_until(PH_PLAY, "climb_play");
    end
    chk("s2_win", score_2, WIN);

    // Start key pressed during POINT and held into OVER: no restart.
    n = 0;
    while (m_phase != PH_OVER && n < 3000) begin
      frame_tick = 1'($urandom % 2);
      flag_1 = 1; keys_1 = 5'd5;
      miss_l = 1'($urandom % 2);
      step();
      n++;
    end
    chk("reach_over", state_o, PH_OVER);
    chk("over_winner", winner, 2);
    chk("over_run", ball_run, 0);
    for (int i = 0; i < 8; i++) begin
      miss_l = 1; miss_r = 1'($urandom % 2); frame_tick = 1'($urandom % 2);
      step();
    end
    chk("over_held_state", state_o, PH_OVER);
    chk("over_held_s2", score_2, WIN);

    quiet();
    step();
    flag_2 = 1; keys_2 = 5'd5;
    step();
    chk("restart_state", state_o, PH_SERVE);
    chk("restart_reset", ball_reset, 1);
    chk("restart_s2", score_2, 0);
    chk("restart_winner", winner, 0);

    run_until(PH_PLAY, "game2_play");
    for (int i = 0; i < 4; i++) begin
      n = $urandom % 3;
      miss(n != 1, n != 0);
      run_until(PH_SERVE, "game2_serve");
      run_until(PH_PLAY, "game2_play_again");
    end

    // Reset in the middle of play.
    noise(0);
    rst = 1;
    step();
    rst = 0;
    chk("midrst_state", state_o, PH_IDLE);
    chk("midrst_s1", score_1, 0);
    chk("midrst_s2", score_2, 0);
    chk("midrst_run", ball_run, 0);
    chk("midrst_winner", winner, 0);
    quiet();
    for (int i = 0; i < 3; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
